mc_sequencer: RTL and testbench

Multicycle control sequencer for the MIPS-style core. It steps each instruction through IDLE/FETCH/DECODE/EXEC/MEM/WB/TRAP phases, handshakes with the instruction and data memories, and issues one-cycle write strobes to the PC, IR, register file and data memory. It sits beside the combinational decode controller, which still drives ALU and mux selects. This block owns only *when* state-changing strobes fire, so the single-cycle datapath can run against memories with variable latency.

---
 rtl/mc_sequencer.sv | 229 ++++++++++++++++++++++
 tb/tb_mc_sequencer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_sequencer.sv
// Multicycle control sequencer: steps IDLE/FETCH/DECODE/EXEC/MEM/WB/TRAP and fires one-cycle state strobes.
// Optional performance counters are built only when SEQ_PERF_CNT_EN is defined.
package the_pkg;
  typedef enum logic [5:0] {
    Rtype  = 6'h00,
    ADDI   = 6'h01,
    SUBI   = 6'h02,
    ANDI   = 6'h03,
    ORI    = 6'h04,
    XORI   = 6'h05,
    LUI_op = 6'h06,
    LLI_op = 6'h07,
    LWR    = 6'h08,
    LWI    = 6'h09,
    SWR    = 6'h0A,
    SWI    = 6'h0B,
    BEQ    = 6'h0C,
    BNE    = 6'h0D,
    JUMP   = 6'h0E,
    RET    = 6'h0F,
    JAL    = 6'h10
  } op_code;

  typedef enum logic [5:0] {
    F_ADD = 6'h00,
    F_SUB = 6'h01,
    F_AND = 6'h02,
    F_OR  = 6'h03,
    F_XOR = 6'h04,
    F_SLT = 6'h05,
    F_SLL = 6'h06,
    F_SRL = 6'h07
  } func_code;
endpackage

module mc_sequencer
  import the_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  op_code      op,
  input  func_code    func,
  input  logic        alu_zero,
  input  logic        im_ready,
  input  logic        dm_ready,
  input  logic        halt_req,
  output logic        im_req,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic        rf_we,
  output logic        dm_re,
  output logic        dm_we,
  output logic        busy,
  output logic        trap,
  output logic [31:0] retired_cnt,
  output logic [31:0] stall_cnt
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  state_t   r_state;
  state_t   w_state_nxt;
  op_code   r_op_q;
  func_code r_func_q;
  logic     r_taken_q;

  logic       w_taken;
  logic       w_is_load;
  logic       w_im_req;
  logic       w_ir_we;
  logic       w_pc_we;
  logic [1:0] w_pc_src;
  logic       w_rf_we;
  logic       w_dm_re;
  logic       w_dm_we;
  logic       w_trap;

  function automatic logic f_legal(input op_code o, input func_code f);
    logic ok;
    ok = 1'b0;
    case (o)
      Rtype: begin
        case (f)
          F_ADD, F_SUB, F_AND, F_OR, F_XOR, F_SLT, F_SLL, F_SRL: ok = 1'b1;
          default: ok = 1'b0;
        endcase
      end
      ADDI, SUBI, ANDI, ORI, XORI, LUI_op, LLI_op,
      LWR, LWI, SWR, SWI, BEQ, BNE, JUMP, RET, JAL: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Branch decision uses the live flag because the PC strobe fires in the EXEC cycle itself.
  assign w_taken   = (r_op_q == BEQ) ? alu_zero : ~alu_zero;
  assign w_is_load = (r_op_q == LWR) || (r_op_q == LWI);

  always_comb begin
    w_state_nxt = r_state;
    w_im_req    = 1'b0;
    w_ir_we     = 1'b0;
    w_pc_we     = 1'b0;
    w_pc_src    = 2'b00;
    w_rf_we     = 1'b0;
    w_dm_re     = 1'b0;
    w_dm_we     = 1'b0;
    w_trap      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!halt_req) w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        w_im_req = 1'b1;
        if (im_ready) begin
          w_ir_we     = 1'b1;
          w_state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        w_state_nxt = f_legal(op, func) ? S_EXEC : S_TRAP;
      end
      S_EXEC: begin
        case (r_op_q)
          Rtype, ADDI, SUBI, ANDI, ORI, XORI, LUI_op, LLI_op, JAL: w_state_nxt = S_WB;
          LWR, LWI, SWR, SWI: w_state_nxt = S_MEM;
          BEQ, BNE: begin
            w_pc_we     = 1'b1;
            w_pc_src    = {1'b0, w_taken};
            w_state_nxt = S_FETCH;
          end
          JUMP: begin
            w_pc_we     = 1'b1;
            w_pc_src    = 2'b10;
            w_state_nxt = S_FETCH;
          end
          RET: begin
            w_pc_we     = 1'b1;
            w_pc_src    = 2'b11;
            w_state_nxt = S_FETCH;
          end
          default: w_state_nxt = S_TRAP;
        endcase
      end
      S_MEM: begin
        w_dm_re = w_is_load;
        w_dm_we = ~w_is_load;
        if (dm_ready) begin
          if (w_is_load) begin
            w_state_nxt = S_WB;
          end else begin
            w_pc_we     = 1'b1;
            w_state_nxt = S_FETCH;
          end
        end
      end
      S_WB: begin
        w_rf_we     = 1'b1;
        w_pc_we     = 1'b1;
        w_pc_src    = (r_op_q == JAL) ? 2'b10 : 2'b00;
        w_state_nxt = S_FETCH;
      end
      S_TRAP: begin
        w_trap = 1'b1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // Every PC update is an instruction boundary, the only place a halt is honoured.
    if (w_pc_we && halt_req) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_op_q    <= op_code'(6'h00);
      r_func_q  <= func_code'(6'h00);
      r_taken_q <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_op_q    <= (r_state == S_DECODE) ? op : r_op_q;
      r_func_q  <= (r_state == S_DECODE) ? func : r_func_q;
      r_taken_q <= (r_state == S_EXEC) ? w_taken : r_taken_q;
    end
  end

  assign im_req = w_im_req;
  assign ir_we  = w_ir_we;
  assign pc_we  = w_pc_we;
  assign pc_src = w_pc_src;
  assign rf_we  = w_rf_we;
  assign dm_re  = w_dm_re;
  assign dm_we  = w_dm_we;
  assign trap   = w_trap;
  assign busy   = (r_state != S_IDLE) && (r_state != S_TRAP);

`ifdef SEQ_PERF_CNT_EN
  logic [31:0] r_retired_cnt;
  logic [31:0] r_stall_cnt;
  logic        w_stall;

  assign w_stall = ((r_state == S_FETCH) && !im_ready) || ((r_state == S_MEM) && !dm_ready);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_retired_cnt <= 32'h0;
      r_stall_cnt   <= 32'h0;
    end else begin
      if (w_pc_we) r_retired_cnt <= r_retired_cnt + 32'd1;
      if (w_stall) r_stall_cnt   <= r_stall_cnt + 32'd1;
    end
  end

  assign retired_cnt = r_retired_cnt;
  assign stall_cnt   = r_stall_cnt;
`else
  assign retired_cnt = 32'h0;
  assign stall_cnt   = 32'h0;
`endif

endmodule

// File: tb/tb_mc_sequencer.sv
// Directed bench for mc_sequencer: per-cycle strobe vectors against hand-computed expectations.
module tb_mc_sequencer;
  import the_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  op_code      op;
  func_code    func;
  logic        alu_zero;
  logic        im_ready;
  logic        dm_ready;
  logic        halt_req;
  logic        im_req, ir_we, pc_we, rf_we, dm_re, dm_we, busy, trap;
  logic [1:0]  pc_src;
  logic [31:0] retired_cnt, stall_cnt;
  logic [9:0]  w_obs;

  int n_checks = 0;
  int n_errors = 0;

  // {im_req, ir_we, pc_we, pc_src[1:0], rf_we, dm_re, dm_we, busy, trap}
  localparam logic [9:0] V_IDLE   = 10'b0000000000;
  localparam logic [9:0] V_FETCH  = 10'b1100000010;
  localparam logic [9:0] V_FETCHW = 10'b1000000010;
  localparam logic [9:0] V_BUSY   = 10'b0000000010;
  localparam logic [9:0] V_WB     = 10'b0010010010;
  localparam logic [9:0] V_WBJ    = 10'b0011010010;
  localparam logic [9:0] V_LD     = 10'b0000001010;
  localparam logic [9:0] V_ST     = 10'b0000000110;
  localparam logic [9:0] V_STDONE = 10'b0010000110;
  localparam logic [9:0] V_BR_T   = 10'b0010100010;
  localparam logic [9:0] V_BR_N   = 10'b0010000010;
  localparam logic [9:0] V_JUMP   = 10'b0011000010;
  localparam logic [9:0] V_RET    = 10'b0011100010;
  localparam logic [9:0] V_TRAP   = 10'b0000000001;

`ifdef SEQ_PERF_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  assign w_obs = {im_req, ir_we, pc_we, pc_src, rf_we, dm_re, dm_we, busy, trap};

  always #5 clk = ~clk;

  mc_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .op          (op),
    .func        (func),
    .alu_zero    (alu_zero),
    .im_ready    (im_ready),
    .dm_ready    (dm_ready),
    .halt_req    (halt_req),
    .im_req      (im_req),
    .ir_we       (ir_we),
    .pc_we       (pc_we),
    .pc_src      (pc_src),
    .rf_we       (rf_we),
    .dm_re       (dm_re),
    .dm_we       (dm_we),
    .busy        (busy),
    .trap        (trap),
    .retired_cnt (retired_cnt),
    .stall_cnt   (stall_cnt)
  );

  task automatic test_reset;
    rst_n = 1'b0; halt_req = 1'b1; im_ready = 1'b0; dm_ready = 1'b0;
    alu_zero = 1'b0; op = ADDI; func = F_ADD;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if (w_obs !== V_IDLE) begin n_errors++; $display("FAIL reset_outputs: got %b expected %b", w_obs, V_IDLE); end
    n_checks++;
    if (retired_cnt !== 32'h0 || stall_cnt !== 32'h0) begin
      n_errors++; $display("FAIL reset_counters: got %0d/%0d expected 0/0", retired_cnt, stall_cnt);
    end
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (w_obs !== V_IDLE) begin n_errors++; $display("FAIL release_cycle: got %b expected %b", w_obs, V_IDLE); end
    @(negedge clk); #1;
    n_checks++;
    if (w_obs !== V_IDLE) begin n_errors++; $display("FAIL idle_halt_hold: got %b expected %b", w_obs, V_IDLE); end
  endtask

  task automatic test_addi;
    logic [9:0] exp [0:4];
    exp = '{V_FETCH, V_BUSY, V_BUSY, V_WB, V_IDLE};
    @(negedge clk);
    op = ADDI; im_ready = 1'b1; dm_ready = 1'b1; halt_req = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      halt_req = 1'b1;
      #1;
      n_checks++;
      if (w_obs !== exp[c]) begin n_errors++; $display("FAIL addi cycle %0d: got %b expected %b", c, w_obs, exp[c]); end
    end
    n_checks++;
    if (retired_cnt !== (CNT_ON ? 32'd1 : 32'd0)) begin
      n_errors++; $display("FAIL addi_retired: got %0d expected %0d", retired_cnt, CNT_ON ? 1 : 0);
    end
  endtask

  task automatic test_load;
    logic [9:0] exp [0:8];
    exp = '{V_FETCH, V_BUSY, V_BUSY, V_LD, V_LD, V_LD, V_LD, V_WB, V_IDLE};
    @(negedge clk);
    op = LWR; im_ready = 1'b1; dm_ready = 1'b0; halt_req = 1'b0;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      halt_req = 1'b1;
      dm_ready = (c == 6);
      #1;
      n_checks++;
      if (w_obs !== exp[c]) begin n_errors++; $display("FAIL load cycle %0d: got %b expected %b", c, w_obs, exp[c]); end
    end
    n_checks++;
    if (stall_cnt !== (CNT_ON ? 32'd3 : 32'd0)) begin
      n_errors++; $display("FAIL load_stall: got %0d expected %0d", stall_cnt, CNT_ON ? 3 : 0);
    end
  endtask

  task automatic test_branch;
    op_code     ops [0:4];
    logic       zs  [0:4];
    logic [9:0] ev  [0:4];
    logic [9:0] exp;
    ops = '{BEQ, BNE, BNE, JUMP, BEQ};
    zs  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    ev  = '{V_BR_T, V_BR_N, V_BR_T, V_JUMP, V_BR_N};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      op = ops[i]; alu_zero = zs[i]; im_ready = 1'b1; halt_req = 1'b0;
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        halt_req = 1'b1;
        #1;
        exp = (c == 0) ? V_FETCH : (c == 1) ? V_BUSY : (c == 2) ? ev[i] : V_IDLE;
        n_checks++;
        if (w_obs !== exp) begin n_errors++; $display("FAIL branch %0d cycle %0d: got %b expected %b", i, c, w_obs, exp); end
      end
    end
  endtask

  task automatic test_jal_ret;
    logic [9:0] exp [0:4];
    exp = '{V_FETCH, V_BUSY, V_BUSY, V_WBJ, V_IDLE};
    @(negedge clk);
    op = JAL; im_ready = 1'b1; halt_req = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      halt_req = (c == 1) || (c >= 3);
      #1;
      n_checks++;
      if (w_obs !== exp[c]) begin n_errors++; $display("FAIL jal cycle %0d: got %b expected %b", c, w_obs, exp[c]); end
    end
    exp = '{V_FETCH, V_BUSY, V_RET, V_IDLE, V_IDLE};
    @(negedge clk);
    op = RET; halt_req = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      halt_req = 1'b1;
      #1;
      n_checks++;
      if (w_obs !== exp[c]) begin n_errors++; $display("FAIL ret cycle %0d: got %b expected %b", c, w_obs, exp[c]); end
    end
  endtask

  task automatic test_store_halt;
    logic [9:0] exp [0:13];
    exp = '{V_FETCH, V_BUSY, V_BUSY, V_ST, V_ST, V_STDONE, V_IDLE, V_IDLE,
            V_FETCHW, V_FETCH, V_BUSY, V_BUSY, V_WB, V_IDLE};
    @(negedge clk);
    op = SWI; im_ready = 1'b1; dm_ready = 1'b0; halt_req = 1'b0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (c == 3) halt_req = 1'b1;
      dm_ready = (c == 5);
      if (c == 7) halt_req = 1'b0;
      if (c == 8) begin halt_req = 1'b1; im_ready = 1'b0; op = ADDI; end
      if (c == 9) im_ready = 1'b1;
      #1;
      n_checks++;
      if (w_obs !== exp[c]) begin n_errors++; $display("FAIL store_halt cycle %0d: got %b expected %b", c, w_obs, exp[c]); end
    end
    n_checks++;
    if (retired_cnt !== (CNT_ON ? 32'd11 : 32'd0) || stall_cnt !== (CNT_ON ? 32'd6 : 32'd0)) begin
      n_errors++;
      $display("FAIL counters: got %0d/%0d expected %0d/%0d", retired_cnt, stall_cnt, CNT_ON ? 11 : 0, CNT_ON ? 6 : 0);
    end
  endtask

  task automatic test_reset_mid_mem;
    logic [9:0] exp [0:3];
    exp = '{V_FETCH, V_BUSY, V_BUSY, V_ST};
    @(negedge clk);
    op = SWR; im_ready = 1'b1; dm_ready = 1'b0; halt_req = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #1;
      n_checks++;
      if (w_obs !== exp[c]) begin n_errors++; $display("FAIL mid_mem cycle %0d: got %b expected %b", c, w_obs, exp[c]); end
    end
    rst_n = 1'b0; halt_req = 1'b1;
    @(negedge clk); #1;
    n_checks++;
    if (w_obs !== V_IDLE) begin n_errors++; $display("FAIL mid_mem_reset: got %b expected %b", w_obs, V_IDLE); end
    n_checks++;
    if (retired_cnt !== 32'h0 || stall_cnt !== 32'h0) begin
      n_errors++; $display("FAIL mid_mem_counters: got %0d/%0d expected 0/0", retired_cnt, stall_cnt);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_trap;
    logic [9:0] exp;
    @(negedge clk);
    op = Rtype; func = func_code'(6'h3F); im_ready = 1'b1; dm_ready = 1'b1; halt_req = 1'b0;
    for (int c = 0; c < 22; c++) begin
      @(negedge clk); #1;
      exp = (c == 0) ? V_FETCH : (c == 1) ? V_BUSY : V_TRAP;
      n_checks++;
      if (w_obs !== exp) begin n_errors++; $display("FAIL trap_func cycle %0d: got %b expected %b", c, w_obs, exp); end
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; halt_req = 1'b1;
    #1;
    n_checks++;
    if (w_obs !== V_IDLE) begin n_errors++; $display("FAIL trap_clear: got %b expected %b", w_obs, V_IDLE); end
    @(negedge clk);
    op = op_code'(6'h3E); func = F_ADD; halt_req = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #1;
      exp = (c == 0) ? V_FETCH : (c == 1) ? V_BUSY : V_TRAP;
      n_checks++;
      if (w_obs !== exp) begin n_errors++; $display("FAIL trap_op cycle %0d: got %b expected %b", c, w_obs, exp); end
    end
    rst_n = 1'b0; halt_req = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_addi();
    test_load();
    test_branch();
    test_jal_ret();
    test_store_halt();
    test_reset_mid_mem();
    test_trap();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
